// File: rtl/spi_motor_cmd_rx_pkg.sv
// Shared types and constants for the SPI motor command receiver.
// The frame checksum helper lives here so the RTL and any reuse agree on one definition.
package motor_cmd_pkg;

  typedef struct packed {
    logic       sign;
    logic [6:0] period;
  } motor_cmd_t;

  localparam int         FRAME_BITS = 24;
  localparam logic [7:0] CHK_SEED   = 8'h5A;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} spi_rx_state_t;

  function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
    return f[7:0] == (f[23:16] ^ f[15:8] ^ CHK_SEED);
  endfunction

endpackage

// File: rtl/spi_motor_cmd_rx_if.sv
// SPI pins from the MCU plus the command outputs toward motor_controller.
// slave is the receiver side, master is the MCU/consumer side.
interface spi_motor_cmd_rx_if;
  logic       sck;
  logic       cs_n;
  logic       mosi;
  logic       motor1_sign;
  logic [6:0] motor1_period;
  logic       motor2_sign;
  logic [6:0] motor2_period;
  logic       cmd_update;
  logic       frame_err;
  logic       timeout;

  modport slave (
    input  sck, cs_n, mosi,
    output motor1_sign, motor1_period, motor2_sign, motor2_period,
    output cmd_update, frame_err, timeout
  );

  modport master (
    output sck, cs_n, mosi,
    input  motor1_sign, motor1_period, motor2_sign, motor2_period,
    input  cmd_update, frame_err, timeout
  );
endinterface

// File: rtl/spi_motor_cmd_rx_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with rise/fall pulses on the synced level.
// Not reset: edges only fire on real pin transitions, so reset mid-frame cannot fake a cs_n fall.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    chain <= {chain[STAGES-2:0], din};
    prev  <= chain[STAGES-1];
  end

  assign level = chain[STAGES-1];
  assign rise  = chain[STAGES-1] & ~prev;
  assign fall  = ~chain[STAGES-1] & prev;
endmodule

// File: rtl/spi_motor_cmd_rx.sv
// 3-wire SPI slave (mode 0, MSB first) receiving checksummed 24-bit motor commands.
// Outputs update two cycles after the synced cs_n rise; a watchdog forces a safe stop.
module spi_motor_cmd_rx
  import motor_cmd_pkg::*;
#(
  parameter logic [23:0] WDT_CYCLES  = 24'd600000,
  parameter logic [6:0]  SAFE_PERIOD = 7'd0,
  parameter int          SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               reset,
  spi_motor_cmd_rx_if.slave bus
);
  logic sck_rise, sck_level_unused, sck_fall_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .din(bus.sck), .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall_unused)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .din(bus.cs_n), .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .din(bus.mosi), .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_rx_state_t         state, state_nxt;
  logic [FRAME_BITS-1:0] shift_q;
  logic [4:0]            bit_cnt;
  logic                  frame_valid, frame_bad;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_valid = 1'b0;
    frame_bad   = 1'b0;
    case (state)
      IDLE:  if (cs_fall) state_nxt = SHIFT;
      SHIFT: if (cs_rise) state_nxt = CHECK;
      CHECK: begin
        state_nxt   = IDLE;
        frame_valid = (bit_cnt == 5'(FRAME_BITS)) && frame_ok(shift_q);
        frame_bad   = ~frame_valid;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter saturates so long frames can never alias back to a count of 24.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (state == IDLE && cs_fall) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (state == SHIFT && sck_rise) begin
      shift_q <= {shift_q[FRAME_BITS-2:0], mosi_s};
      if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
    end
  end

  logic [23:0] wdt_cnt;
  logic        wdt_term;
  assign wdt_term = (wdt_cnt == WDT_CYCLES - 24'd1);

  always_ff @(posedge clk) begin
    if (reset || frame_valid) wdt_cnt <= '0;
    else if (!wdt_term)       wdt_cnt <= wdt_cnt + 24'd1;
  end

  motor_cmd_t m1_q, m2_q;
  logic       timeout_q, cmd_update_q, frame_err_q;

  // A commit in the terminal-count cycle takes priority over the forced stop.
  always_ff @(posedge clk) begin
    if (reset) begin
      m1_q         <= '{sign: 1'b0, period: SAFE_PERIOD};
      m2_q         <= '{sign: 1'b0, period: SAFE_PERIOD};
      timeout_q    <= 1'b1;
      cmd_update_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      cmd_update_q <= frame_valid;
      frame_err_q  <= frame_bad;
      if (frame_valid) begin
        m1_q      <= shift_q[23:16];
        m2_q      <= shift_q[15:8];
        timeout_q <= 1'b0;
      end else if (wdt_term) begin
        m1_q      <= '{sign: 1'b0, period: SAFE_PERIOD};
        m2_q      <= '{sign: 1'b0, period: SAFE_PERIOD};
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.motor1_sign   = m1_q.sign;
  assign bus.motor1_period = m1_q.period;
  assign bus.motor2_sign   = m2_q.sign;
  assign bus.motor2_period = m2_q.period;
  assign bus.cmd_update    = cmd_update_q;
  assign bus.frame_err     = frame_err_q;
  assign bus.timeout       = timeout_q;
endmodule

// File: tb/tb_spi_motor_cmd_rx.sv
// Directed bench for spi_motor_cmd_rx: SPI frames driven from one sequence, results
// predicted into a scoreboard queue and popped when cmd_update/frame_err fires.
module tb_spi_motor_cmd_rx;
  import motor_cmd_pkg::*;

  localparam logic [23:0] WDT = 24'd1500;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_motor_cmd_rx_if bus();

  spi_motor_cmd_rx #(.WDT_CYCLES(WDT), .SAFE_PERIOD(7'd0), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic       is_err;
    logic [7:0] m1;
    logic [7:0] m2;
    logic       tmo;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl_m1, mdl_m2;
  logic       mdl_tmo;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [31:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.mosi = d[i];
      bus.sck  = 1'b0;
      tick(4);
      bus.sck  = 1'b1;
      tick(4);
    end
    bus.sck = 1'b0;
    tick(4);
  endtask

  task automatic predict(input logic [31:0] d, input int n);
    logic [23:0] f;
    f = d[23:0];
    if (n == 24 && f[7:0] == (f[23:16] ^ f[15:8] ^ 8'h5A)) begin
      mdl_m1  = f[23:16];
      mdl_m2  = f[15:8];
      mdl_tmo = 1'b0;
      sb.push_back('{is_err: 1'b0, m1: mdl_m1, m2: mdl_m2, tmo: mdl_tmo});
    end else begin
      sb.push_back('{is_err: 1'b1, m1: mdl_m1, m2: mdl_m2, tmo: mdl_tmo});
    end
  endtask

  task automatic check_result(input string tag);
    int   lat;
    logic seen;
    exp_t e;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 12 && !seen; i++) begin
      tick(1);
      if (bus.cmd_update || bus.frame_err) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    e = sb.pop_front();
    chk({tag, "_pulse_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_latency"}, lat, 4);
      chk({tag, "_frame_err"}, 32'(bus.frame_err), 32'(e.is_err));
      chk({tag, "_cmd_update"}, 32'(bus.cmd_update), 32'(!e.is_err));
      chk({tag, "_m1"}, {bus.motor1_sign, bus.motor1_period}, 32'(e.m1));
      chk({tag, "_m2"}, {bus.motor2_sign, bus.motor2_period}, 32'(e.m2));
      chk({tag, "_timeout"}, 32'(bus.timeout), 32'(e.tmo));
      tick(1);
      chk({tag, "_pulse_width"}, {bus.cmd_update, bus.frame_err}, 32'd0);
    end
  endtask

  task automatic send_frame(input string tag, input logic [31:0] d, input int n);
    predict(d, n);
    bus.cs_n = 1'b0;
    tick(4);
    spi_bits(d, n);
    bus.cs_n = 1'b1;
    check_result(tag);
    tick(4);
  endtask

  initial begin
    int upd;
    bus.sck  = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    mdl_m1   = 8'h00;
    mdl_m2   = 8'h00;
    mdl_tmo  = 1'b1;

    tick(3);
    chk("rst_timeout", 32'(bus.timeout), 32'd1);
    chk("rst_m1", {bus.motor1_sign, bus.motor1_period}, 32'd0);
    chk("rst_m2", {bus.motor2_sign, bus.motor2_period}, 32'd0);
    chk("rst_pulses", {bus.cmd_update, bus.frame_err}, 32'd0);
    reset = 1'b0;
    tick(5);

    send_frame("valid1", 32'h9E64A0, 24);
    chk("valid1_m1_sign", 32'(bus.motor1_sign), 32'd1);
    chk("valid1_m1_period", 32'(bus.motor1_period), 32'd30);
    chk("valid1_m2_sign", 32'(bus.motor2_sign), 32'd0);
    chk("valid1_m2_period", 32'(bus.motor2_period), 32'd100);

    send_frame("badchk", 32'h9E64A1, 24);
    send_frame("short16", 32'h0000_9E64, 16);
    send_frame("long32", 32'h1234_5678, 32);

    send_frame("wdt_arm", 32'h0587D8, 24);
    tick(1440);
    chk("wdt_not_yet", 32'(bus.timeout), 32'd0);
    tick(80);
    chk("wdt_timeout", 32'(bus.timeout), 32'd1);
    chk("wdt_m1_safe", {bus.motor1_sign, bus.motor1_period}, 32'd0);
    chk("wdt_m2_safe", {bus.motor2_sign, bus.motor2_period}, 32'd0);
    mdl_m1  = 8'h00;
    mdl_m2  = 8'h00;
    mdl_tmo = 1'b1;
    send_frame("wdt_clear", 32'h7F0124, 24);

    bus.cs_n = 1'b0;
    tick(4);
    spi_bits(32'h9E6, 12);
    reset = 1'b1;
    tick(3);
    reset   = 1'b0;
    mdl_m1  = 8'h00;
    mdl_m2  = 8'h00;
    mdl_tmo = 1'b1;
    chk("midrst_timeout", 32'(bus.timeout), 32'd1);
    spi_bits(32'h4A0, 12);
    bus.cs_n = 1'b1;
    upd = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.cmd_update) upd++;
    end
    chk("midrst_no_update", upd, 0);
    chk("midrst_m1", {bus.motor1_sign, bus.motor1_period}, 32'd0);
    tick(4);
    send_frame("after_rst", 32'h9E64A0, 24);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
